prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 94 +++++++++
 tb/tb_prog_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - program memory loader and run/halt/step controller for a small CPU
// Optional breakpoint unit enabled by defining PROG_LOADER_BREAKPOINT_EN.
module prog_loader (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       cmd_run,
  input  logic       cmd_halt,
  input  logic       cmd_step,
  input  logic [3:0] cpu_addr,
  output logic [7:0] cpu_data,
  output logic       cpu_n_reset,
  output logic       cpu_ce,
  output logic [1:0] ctrl_state,
`ifdef PROG_LOADER_BREAKPOINT_EN
  input  logic       bp_valid,
  input  logic [3:0] bp_addr,
  output logic       bp_hit,
`endif
  output logic [7:0] instr_count
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RESET = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_STEP  = 2'b11;

  logic [1:0] state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] mem_q [16];
  logic       wr_fire;
  logic       bp_stop;
  logic [7:0] count_inc;

`ifdef PROG_LOADER_BREAKPOINT_EN
  // Halt wins over a breakpoint: the halting cycle still executes normally.
  assign bp_stop = (state_q == ST_RUN) && bp_valid && (cpu_addr == bp_addr) && !cmd_halt;
  assign bp_hit  = n_reset && bp_stop;
`else
  assign bp_stop = 1'b0;
`endif

  assign wr_ready  = n_reset && (state_q == ST_IDLE);
  assign wr_fire   = wr_valid && wr_ready;
  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_run)       state_d = ST_RESET;
        else if (cmd_step) state_d = ST_STEP;
      end
      ST_RESET: state_d = ST_RUN;
      ST_RUN: begin
        if (cmd_halt || bp_stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case (state_q)
      ST_RESET: count_d = 8'd0;
      ST_RUN:   if (!bp_stop) count_d = count_inc;
      ST_STEP:  count_d = count_inc;
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      count_q <= 8'd0;
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (wr_fire) mem_q[wr_addr] <= wr_data;
    end
  end

  // Controller reset is mirrored onto the CPU combinationally so both reset together.
  assign cpu_data    = mem_q[cpu_addr];
  assign cpu_n_reset = n_reset && (state_q != ST_RESET);
  assign cpu_ce      = !n_reset || ((state_q != ST_IDLE) && !bp_stop);
  assign ctrl_state  = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
// Breakpoint scenario is built only when PROG_LOADER_BREAKPOINT_EN is defined.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'd0;
  logic       cmd_run = 1'b0;
  logic       cmd_halt = 1'b0;
  logic       cmd_step = 1'b0;
  logic [3:0] cpu_addr = 4'd0;
  logic [7:0] cpu_data;
  logic       cpu_n_reset;
  logic       cpu_ce;
  logic [1:0] ctrl_state;
  logic [7:0] instr_count;
`ifdef PROG_LOADER_BREAKPOINT_EN
  logic       bp_valid = 1'b0;
  logic [3:0] bp_addr = 4'd0;
  logic       bp_hit;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cmd_run    (cmd_run),
    .cmd_halt   (cmd_halt),
    .cmd_step   (cmd_step),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_n_reset(cpu_n_reset),
    .cpu_ce     (cpu_ce),
    .ctrl_state (ctrl_state),
`ifdef PROG_LOADER_BREAKPOINT_EN
    .bp_valid   (bp_valid),
    .bp_addr    (bp_addr),
    .bp_hit     (bp_hit),
`endif
    .instr_count(instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IDLE -> RESET -> RUN, leaves the DUT in its first RUN cycle
  task automatic start_run();
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    tick();
    tick();
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", ctrl_state); end
    checks++; if (cpu_n_reset !== 1'b0) begin errors++; $display("FAIL reset_cpu_n_reset: got %b expected 0", cpu_n_reset); end
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL reset_cpu_ce: got %b expected 1", cpu_ce); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (instr_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    for (int i = 0; i < 16; i++) begin
      cpu_addr = 4'(i);
      #1;
      checks++; if (cpu_data !== 8'h00) begin errors++; $display("FAIL reset_mem[%0d]: got %h expected 00", i, cpu_data); end
    end
    n_reset = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL idle_cpu_ce: got %b expected 0", cpu_ce); end
    checks++; if (cpu_n_reset !== 1'b1) begin errors++; $display("FAIL idle_cpu_n_reset: got %b expected 1", cpu_n_reset); end
  endtask

  task automatic test_load();
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 8'h31;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL load_ready0: got %b expected 1", wr_ready); end
    tick();
    wr_addr = 4'd1; wr_data = 8'hF0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL load_ready1: got %b expected 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    cpu_addr = 4'd0; #1;
    checks++; if (cpu_data !== 8'h31) begin errors++; $display("FAIL load_mem0: got %h expected 31", cpu_data); end
    cpu_addr = 4'd1; #1;
    checks++; if (cpu_data !== 8'hF0) begin errors++; $display("FAIL load_mem1: got %h expected f0", cpu_data); end
  endtask

  task automatic test_run_halt();
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    checks++; if (ctrl_state !== 2'b01) begin errors++; $display("FAIL run_reset_state: got %b expected 01", ctrl_state); end
    checks++; if (cpu_n_reset !== 1'b0) begin errors++; $display("FAIL run_cpu_n_reset: got %b expected 0", cpu_n_reset); end
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL run_reset_ce: got %b expected 1", cpu_ce); end
    tick();
    checks++; if (ctrl_state !== 2'b10) begin errors++; $display("FAIL run_state: got %b expected 10", ctrl_state); end
    checks++; if (cpu_n_reset !== 1'b1) begin errors++; $display("FAIL run_cpu_n_reset_hi: got %b expected 1", cpu_n_reset); end
    checks++; if (instr_count !== 8'd0) begin errors++; $display("FAIL run_count_clear: got %0d expected 0", instr_count); end
    for (int i = 0; i < 9; i++) tick();
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL halt_state: got %b expected 00", ctrl_state); end
    checks++; if (instr_count !== 8'd10) begin errors++; $display("FAIL halt_count: got %0d expected 10", instr_count); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL halt_cpu_ce: got %b expected 0", cpu_ce); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL halt_wr_ready: got %b expected 1", wr_ready); end
  endtask

  task automatic test_write_during_run();
    start_run();
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'hAA; cpu_addr = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL run_wr_ready[%0d]: got %b expected 0", i, wr_ready); end
      tick();
    end
    checks++; if (cpu_data !== 8'h00) begin errors++; $display("FAIL run_mem3_unchanged: got %h expected 00", cpu_data); end
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
    checks++; if (cpu_data !== 8'h00) begin errors++; $display("FAIL halt_mem3_pending: got %h expected 00", cpu_data); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL halt_wr_accept: got %b expected 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    checks++; if (cpu_data !== 8'hAA) begin errors++; $display("FAIL mem3_written: got %h expected aa", cpu_data); end
  endtask

  task automatic test_simultaneous();
    start_run();
    cmd_halt = 1'b1; cmd_run = 1'b1;
    tick();
    cmd_halt = 1'b0; cmd_run = 1'b0;
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL halt_run_state: got %b expected 00", ctrl_state); end
    checks++; if (instr_count !== 8'd1) begin errors++; $display("FAIL halt_run_count: got %0d expected 1", instr_count); end
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL idle_halt_ignored: got %b expected 00", ctrl_state); end
    cpu_addr = 4'd5; wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 8'hB5; cmd_step = 1'b1;
    tick();
    wr_valid = 1'b0; cmd_step = 1'b0;
    checks++; if (ctrl_state !== 2'b11) begin errors++; $display("FAIL step_state: got %b expected 11", ctrl_state); end
    checks++; if (cpu_data !== 8'hB5) begin errors++; $display("FAIL step_fetch: got %h expected b5", cpu_data); end
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL step_ce: got %b expected 1", cpu_ce); end
    checks++; if (cpu_n_reset !== 1'b1) begin errors++; $display("FAIL step_no_reset: got %b expected 1", cpu_n_reset); end
    tick();
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL step_return: got %b expected 00", ctrl_state); end
    checks++; if (instr_count !== 8'd2) begin errors++; $display("FAIL step_count: got %0d expected 2", instr_count); end
    cmd_run = 1'b1; cmd_step = 1'b1;
    tick();
    cmd_run = 1'b0; cmd_step = 1'b0;
    checks++; if (ctrl_state !== 2'b01) begin errors++; $display("FAIL run_over_step: got %b expected 01", ctrl_state); end
    tick();
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
  endtask

  task automatic test_saturation();
    start_run();
    for (int i = 0; i < 300; i++) tick();
    checks++; if (instr_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", instr_count); end
    checks++; if (ctrl_state !== 2'b10) begin errors++; $display("FAIL sat_state: got %b expected 10", ctrl_state); end
  endtask

  task automatic test_reset_abort();
    n_reset = 1'b0;
    #1;
    checks++; if (cpu_n_reset !== 1'b0) begin errors++; $display("FAIL abort_cpu_n_reset: got %b expected 0", cpu_n_reset); end
    tick();
    n_reset = 1'b1;
    cpu_addr = 4'd3;
    #1;
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL abort_state: got %b expected 00", ctrl_state); end
    checks++; if (instr_count !== 8'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", instr_count); end
    checks++; if (cpu_data !== 8'h00) begin errors++; $display("FAIL abort_mem3: got %h expected 00", cpu_data); end
  endtask

`ifdef PROG_LOADER_BREAKPOINT_EN
  task automatic test_breakpoint();
    bp_valid = 1'b1; bp_addr = 4'd2; cpu_addr = 4'd0;
    start_run();
    tick();
    cpu_addr = 4'd1;
    tick();
    cpu_addr = 4'd2;
    #1;
    checks++; if (bp_hit !== 1'b1) begin errors++; $display("FAIL bp_hit: got %b expected 1", bp_hit); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL bp_ce: got %b expected 0", cpu_ce); end
    tick();
    checks++; if (ctrl_state !== 2'b00) begin errors++; $display("FAIL bp_state: got %b expected 00", ctrl_state); end
    checks++; if (instr_count !== 8'd2) begin errors++; $display("FAIL bp_count: got %0d expected 2", instr_count); end
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_hit_clear: got %b expected 0", bp_hit); end
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_step_hit: got %b expected 0", bp_hit); end
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL bp_step_ce: got %b expected 1", cpu_ce); end
    tick();
    checks++; if (instr_count !== 8'd3) begin errors++; $display("FAIL bp_step_count: got %0d expected 3", instr_count); end
    bp_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_run_halt();
    test_write_during_run();
    test_simultaneous();
    test_saturation();
    test_reset_abort();
`ifdef PROG_LOADER_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
